// File: rtl/fixed_to_float_pkg.sv
// Shared encodings, default widths and the packed float layout for the
// fixed-point to float converter.
package fixed_to_float_pkg;

   // Rounding-mode encodings as seen on the round_mode port.
   typedef enum logic [1:0] {
      RM_RNE = 2'b00,  // round to nearest, ties to even
      RM_RTZ = 2'b01,  // round toward zero
      RM_POS = 2'b10,  // round toward +infinity
      RM_NEG = 2'b11   // round toward -infinity
   } round_mode_e;

   // Default widths (binary32 output from a 32-bit fixed-point word).
   localparam int DEF_IN_W  = 32;
   localparam int DEF_EXP_W = 8;
   localparam int DEF_MAN_W = 23;
   localparam int DEF_BIAS  = 2**(DEF_EXP_W-1) - 1;

   // Packed float with the default widths: {sign, biased exponent, fraction}.
   typedef struct packed {
      logic                 sign;
      logic [DEF_EXP_W-1:0] exp;
      logic [DEF_MAN_W-1:0] frac;
   } float_t;

endpackage

// File: rtl/fixed_to_float_pipe_lead_one_detect.sv
// Combinational priority encoder: index of the most significant set bit of
// mag_i, plus a flag for an all-zero input (index reads 0 in that case).
module lead_one_detect #(
   parameter int IN_W  = 32,
   parameter int POS_W = $clog2(IN_W)
) (
   input  logic [IN_W-1:0]  mag_i,
   output logic [POS_W-1:0] lead_o,
   output logic             zero_o
);

   // Scan upward so the highest set bit is the last one to write lead_o.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
      lead_o = '0;
      zero_o = (mag_i == '0);
      for (int i = 0; i < IN_W; i++) begin
         if (mag_i[i]) lead_o = POS_W'(i);
      end
   end

endmodule

// File: rtl/fixed_to_float_pipe.sv
// Three-stage fixed-point to IEEE-754 converter with valid/ready streaming.
// S1 forms sign/magnitude, S2 normalises, S3 rounds and packs. A single
// advance signal moves or holds the whole pipe.
module fixed_to_float_pipe
   import fixed_to_float_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int POS_W = $clog2(IN_W),
   parameter int EXP_W = DEF_EXP_W,
   parameter int MAN_W = DEF_MAN_W,
   parameter int BIAS  = 2**(EXP_W-1) - 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [IN_W-1:0]          targetnumber,
   input  logic [POS_W-1:0]         fixpointpos,
   input  logic                     is_signed,
   input  logic [1:0]               round_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     result,
   output logic                     inexact
);

   localparam int OUT_W = 1 + EXP_W + MAN_W;
   localparam int E2    = EXP_W + 2;          // signed exponent working width
   localparam int NW    = IN_W + MAN_W + 1;   // normalised bits below the leading one
   localparam logic signed [E2-1:0] EXP_ZERO = '0;
   localparam logic signed [E2-1:0] EXP_MAX  = E2'((1 << EXP_W) - 1);

   logic adv;

   // Stage 1 registers
   logic              s1_valid_q;
   logic              s1_sign_q,  s1_sign_d;
   logic [IN_W-1:0]   s1_mag_q,   s1_mag_d;
   round_mode_e       s1_rm_q;
   logic [POS_W-1:0]  s1_pos_q;

   // Stage 2 registers
   logic                    s2_valid_q;
   logic                    s2_sign_q;
   logic                    s2_zero_q,   s2_zero_d;
   round_mode_e             s2_rm_q;
   logic [MAN_W-1:0]        s2_frac_q,   s2_frac_d;
   logic                    s2_guard_q,  s2_guard_d;
   logic                    s2_sticky_q, s2_sticky_d;
   logic signed [E2-1:0]    s2_exp_q,    s2_exp_d;

   // Stage 3 (output) registers
   logic              out_valid_q;
   logic [OUT_W-1:0]  result_q,  result_d;
   logic              inexact_q, inexact_d;

   logic [POS_W-1:0]  lead;
   logic              mag_zero;
   logic [NW-1:0]     norm;

   logic              inc;
   logic [MAN_W:0]    frac_sum;
   logic signed [E2-1:0] exp_r;

   // The whole pipe moves unless a result is waiting on a stalled sink.
   assign adv       = !out_valid_q | out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign inexact   = inexact_q;

   // S1: sign and magnitude; -2^(IN_W-1) negates to itself, which reads
   // correctly as an unsigned magnitude.
   always_comb begin
      s1_sign_d = is_signed & targetnumber[IN_W-1];
      s1_mag_d  = s1_sign_d ? (~targetnumber + IN_W'(1)) : targetnumber;
   end

   // S1 register: capture the operand together with its mode and binary point.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so each stage samples the previous stage's old value on the same edge.
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_mag_q   <= '0;
         s1_rm_q    <= RM_RNE;
         s1_pos_q   <= '0;
      end else if (adv) begin
         s1_valid_q <= in_valid;
         s1_sign_q  <= s1_sign_d;
         s1_mag_q   <= s1_mag_d;
         s1_rm_q    <= round_mode_e'(round_mode);
         s1_pos_q   <= fixpointpos;
      end
   end

   lead_one_detect #(
      .IN_W  (IN_W),
      .POS_W (POS_W)
   ) u_lod (
      .mag_i  (s1_mag_q),
      .lead_o (lead),
      .zero_o (mag_zero)
   );

   // S2: shift the leading one just out of the top so the remaining bits are
   // fraction, guard and sticky in that order; the low padding keeps this
   // valid when the input is narrower than the fraction.
   always_comb begin
      norm        = {s1_mag_q, {(MAN_W+1){1'b0}}} << (IN_W - int'(lead));
      s2_frac_d   = norm[NW-1 -: MAN_W];
      s2_guard_d  = norm[IN_W];
      s2_sticky_d = |norm[IN_W-1:0];
      s2_zero_d   = mag_zero;
      s2_exp_d    = E2'(BIAS) + E2'(lead) - E2'(s1_pos_q);
   end

   // S2 register: normalised fraction, rounding bits and unbiased-checked exponent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q  <= 1'b0;
         s2_sign_q   <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_rm_q     <= RM_RNE;
         s2_frac_q   <= '0;
         s2_guard_q  <= 1'b0;
         s2_sticky_q <= 1'b0;
         s2_exp_q    <= '0;
      end else if (adv) begin
         s2_valid_q  <= s1_valid_q;
         s2_sign_q   <= s1_sign_q;
         s2_zero_q   <= s2_zero_d;
         s2_rm_q     <= s1_rm_q;
         s2_frac_q   <= s2_frac_d;
         s2_guard_q  <= s2_guard_d;
         s2_sticky_q <= s2_sticky_d;
         s2_exp_q    <= s2_exp_d;
      end
   end

   // S3: round, renormalise on fraction carry-out, then saturate or flush.
   always_comb begin
      case (s2_rm_q)
         RM_RNE:  inc = s2_guard_q & (s2_sticky_q | s2_frac_q[0]);
         RM_RTZ:  inc = 1'b0;
         RM_POS:  inc = !s2_sign_q & (s2_guard_q | s2_sticky_q);
         RM_NEG:  inc = s2_sign_q & (s2_guard_q | s2_sticky_q);
         default: inc = 1'b0;
      endcase
      frac_sum  = {1'b0, s2_frac_q} + (MAN_W+1)'(inc);
      exp_r     = s2_exp_q + E2'(frac_sum[MAN_W]);
      result_d  = {s2_sign_q, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
      inexact_d = s2_guard_q | s2_sticky_q;
      if (s2_zero_q) begin
         result_d  = '0;
         inexact_d = 1'b0;
      end else if (exp_r >= EXP_MAX) begin
         result_d  = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         inexact_d = 1'b1;
      end else if (exp_r <= EXP_ZERO) begin
         result_d  = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
         inexact_d = 1'b1;
      end
   end

   // S3 register: presented result, held while the sink stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         inexact_q   <= 1'b0;
      end else if (adv) begin
         out_valid_q <= s2_valid_q;
         result_q    <= result_d;
         inexact_q   <= inexact_d;
      end
   end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Scoreboard bench for fixed_to_float_pipe: the driver queues the expected
// result at each accepted transfer; a monitor pops and compares at each retire.
module tb_fixed_to_float_pipe;
   import fixed_to_float_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] targetnumber;
   logic [4:0]  fixpointpos;
   logic        is_signed;
   logic [1:0]  round_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        inexact;

   typedef struct packed {
      logic [31:0] res;
      logic        inx;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   retired = 0;

   logic [31:0] stream_exp [6] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                                   32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};

   always #5 clk = ~clk;

   fixed_to_float_pipe dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .targetnumber (targetnumber),
      .fixpointpos  (fixpointpos),
      .is_signed    (is_signed),
      .round_mode   (round_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .inexact      (inexact)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Present one word (called just after a falling edge); returns on the
   // falling edge after it was accepted, with in_valid still asserted.
   task automatic send(input logic [31:0] t, input logic [4:0] pos, input logic sgn,
                       input round_mode_e rm, input logic [31:0] er, input logic ei,
                       input bit track);
      int  budget = 0;
      bit  done   = 0;
      targetnumber = t;
      fixpointpos  = pos;
      is_signed    = sgn;
      round_mode   = rm;
      in_valid     = 1'b1;
      while (!done) begin
         #1;
         if (in_ready) begin
            @(posedge clk);
            if (track) sb_q.push_back('{res: er, inx: ei});
            @(negedge clk);
            done = 1;
         end else if (budget > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 for %0d cycles, expected 1", budget);
            in_valid = 1'b0;
            done = 1;
         end else begin
            budget++;
            @(negedge clk);
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
      end
   endtask

   // Monitor: a retire happens on the next rising edge when valid & ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n === 1'b1 && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: result=0x%0h, expected no output", result);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("result[%0d]", retired), result, e.res);
               check($sformatf("inexact[%0d]", retired), inexact, e.inx);
               retired++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      float_t inf_chk;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      targetnumber = '0;
      fixpointpos  = '0;
      is_signed    = 1'b0;
      round_mode   = RM_RNE;
      out_ready    = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_inexact", inexact, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);

      // Latency: visible in the third cycle after the accepting edge
      send(32'h0000_0003, 5'd0, 1'b0, RM_RNE, 32'h4040_0000, 1'b0, 1);
      in_valid = 1'b0;
      #1 check("lat_c1", out_valid, 0);
      @(negedge clk); #1 check("lat_c2", out_valid, 0);
      @(negedge clk); #1 check("lat_c3", out_valid, 1);
      @(negedge clk);

      // Directed vectors, issued back to back
      send(32'hFFFF_FFFD, 5'd1,  1'b1, RM_RNE, 32'hBFC0_0000, 1'b0, 1);
      send(32'h8000_0000, 5'd0,  1'b1, RM_RNE, 32'hCF00_0000, 1'b0, 1);
      send(32'h8000_0000, 5'd0,  1'b0, RM_RNE, 32'h4F00_0000, 1'b0, 1);
      send(32'h0000_0001, 5'd31, 1'b0, RM_RNE, 32'h3000_0000, 1'b0, 1);
      send(32'h0100_0001, 5'd0,  1'b0, RM_RNE, 32'h4B80_0000, 1'b1, 1);
      send(32'h0100_0003, 5'd0,  1'b0, RM_RNE, 32'h4B80_0002, 1'b1, 1);
      send(32'h0100_0003, 5'd0,  1'b0, RM_RTZ, 32'h4B80_0001, 1'b1, 1);
      send(32'h0100_0003, 5'd0,  1'b0, RM_POS, 32'h4B80_0002, 1'b1, 1);
      send(32'h0100_0003, 5'd0,  1'b0, RM_NEG, 32'h4B80_0001, 1'b1, 1);
      send(32'hFEFF_FFFD, 5'd0,  1'b1, RM_NEG, 32'hCB80_0002, 1'b1, 1);
      send(32'hFEFF_FFFD, 5'd0,  1'b1, RM_POS, 32'hCB80_0001, 1'b1, 1);
      send(32'h01FF_FFFF, 5'd0,  1'b0, RM_RNE, 32'h4C00_0000, 1'b1, 1);
      send(32'h01FF_FFFF, 5'd0,  1'b0, RM_RTZ, 32'h4BFF_FFFF, 1'b1, 1);
      send(32'h0200_0001, 5'd0,  1'b0, RM_RNE, 32'h4C00_0000, 1'b1, 1);
      send(32'h0200_0001, 5'd0,  1'b0, RM_POS, 32'h4C00_0001, 1'b1, 1);
      send(32'h0000_0000, 5'd0,  1'b1, RM_NEG, 32'h0000_0000, 1'b0, 1);
      send(32'h0000_000A, 5'd2,  1'b0, RM_RNE, 32'h4020_0000, 1'b0, 1);
      send(32'hFFFF_FFFF, 5'd0,  1'b1, RM_RNE, 32'hBF80_0000, 1'b0, 1);
      send(32'hFFFF_FFFF, 5'd0,  1'b0, RM_RNE, 32'h4F80_0000, 1'b1, 1);
      in_valid = 1'b0;
      drain();

      // Stall: sink blocked for 5 cycles once the first result is presented
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(32'(i + 1), 5'd0, 1'b0, RM_RNE, stream_exp[i], 1'b0, 1);
            in_valid = 1'b0;
         end
         begin
            int n = 0;
            do begin
               @(negedge clk);
               #1;
               n++;
            end while (!out_valid && n < 20);
            check("stall_valid_rise", out_valid, 1);
            repeat (5) begin
               @(negedge clk);
               #1;
               check("stall_out_valid", out_valid, 1);
               check("stall_result_held", result, 32'h3F80_0000);
               check("stall_in_ready", in_ready, 0);
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();
      check("stream_retired", retired, 26);

      // Reset with two words in flight: they must vanish
      send(32'h0000_0005, 5'd0, 1'b0, RM_RNE, 32'h0, 1'b0, 0);
      send(32'h0000_0006, 5'd0, 1'b0, RM_RNE, 32'h0, 1'b0, 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_result", result, 0);
      check("mid_rst_inexact", inexact, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #1;
         check("post_rst_no_output", out_valid, 0);
      end
      check("post_rst_in_ready", in_ready, 1);

      // Positive infinity layout from the package struct, as a sanity anchor
      inf_chk = '{sign: 1'b0, exp: '1, frac: '0};
      send(32'h0000_0001, 5'd0, 1'b0, RM_RNE, 32'h3F80_0000, 1'b0, 1);
      in_valid = 1'b0;
      drain();
      check("struct_layout_vs_result", {result[31], result[30:23]}, {inf_chk.sign, inf_chk.exp ^ 8'h80});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
